// File: rtl/led_pkg.sv
// Shared constants, types and the duty compare used by the LED PWM shaper.
package led_pkg;
    localparam int PWM_STEPS = 16;
    localparam int DUTY_W    = 4;
    localparam int LED_W     = 16;
    localparam int HL_CNT_W  = 8;
    localparam int DIV_CNT_W = 16;

    localparam logic [DUTY_W-1:0] DUTY_FULL  = 4'hF;
    localparam logic [DUTY_W-1:0] BRIGHT_RST = 4'd8;

    typedef logic [LED_W-1:0]    led_word_t;
    typedef logic [DUTY_W-1:0]   duty_t;
    typedef logic [HL_CNT_W-1:0] hl_cnt_t;

    // Full duty is always on; otherwise on for phases 0..duty (duty+1 of 16).
    function automatic logic pwm_on(input duty_t duty, input duty_t phase);
        return (duty == DUTY_FULL) || (phase <= duty);
    endfunction
endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler and 16-step phase counter that pace the LED brightness PWM.
module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_DIV = 390
) (
    input  logic              ledclk,
    input  logic              ledrst_n,
    output logic              tick,
    output logic [DUTY_W-1:0] phase,
    output logic              period_end
);
    localparam logic [DIV_CNT_W-1:0] DIV_LAST   = DIV_CNT_W'(PWM_DIV - 1);
    localparam logic [DUTY_W-1:0]    PHASE_LAST = DUTY_W'(PWM_STEPS - 1);

    logic [DIV_CNT_W-1:0] div_cnt;

    assign tick       = (div_cnt == DIV_LAST);
    assign period_end = tick & (phase == PHASE_LAST);

    always_ff @(posedge ledclk) begin
        if (!ledrst_n) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= phase + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_pwm_shaper.sv
// LED pin stage: global brightness PWM with a timed full-brightness highlight
// on bits that recently changed.
module led_pwm_shaper
    import led_pkg::*;
#(
    parameter int PWM_DIV    = 390,
    parameter int HL_PERIODS = 200
) (
    input  logic              ledclk,
    input  logic              ledrst_n,
    input  logic [LED_W-1:0]  ledin,
    input  logic              brt_we,
    input  logic [DUTY_W-1:0] brt_wdata,
    output logic [LED_W-1:0]  ledpin,
    output logic              hl_active
);
    localparam hl_cnt_t HL_LOAD = HL_CNT_W'(HL_PERIODS);

    logic        tick;
    duty_t       phase;
    logic        period_end;
    logic        period_step;

    led_word_t   ledq;
    duty_t       bright;
    hl_cnt_t     hl_cnt;
    led_word_t   hl_mask;

    led_word_t   chg;
    hl_cnt_t     hl_cnt_nxt;
    led_word_t   hl_mask_nxt;
    led_word_t   pin_nxt;

    led_pwm_timebase #(
        .PWM_DIV(PWM_DIV)
    ) u_timebase (
        .ledclk    (ledclk),
        .ledrst_n  (ledrst_n),
        .tick      (tick),
        .phase     (phase),
        .period_end(period_end)
    );

    assign chg         = ledin ^ ledq;
    assign period_step = tick & period_end;

    // A fresh change always wins over the period-end countdown.
    always_comb begin
        hl_cnt_nxt  = hl_cnt;
        hl_mask_nxt = hl_mask;
        if (chg != '0) begin
            hl_mask_nxt = hl_mask | chg;
            hl_cnt_nxt  = HL_LOAD;
        end else if (period_step && (hl_cnt != '0)) begin
            hl_cnt_nxt = hl_cnt - 1'b1;
            if (hl_cnt == hl_cnt_t'(1)) begin
                hl_mask_nxt = '0;
            end
        end
    end

    always_comb begin
        pin_nxt = '0;
        for (int i = 0; i < LED_W; i++) begin
            pin_nxt[i] = ledq[i] & pwm_on(hl_mask[i] ? DUTY_FULL : bright, phase);
        end
    end

    always_ff @(posedge ledclk) begin
        if (!ledrst_n) begin
            ledq      <= '0;
            bright    <= BRIGHT_RST;
            hl_cnt    <= '0;
            hl_mask   <= '0;
            ledpin    <= '0;
            hl_active <= 1'b0;
        end else begin
            ledq      <= ledin;
            if (brt_we) begin
                bright <= brt_wdata;
            end
            hl_cnt    <= hl_cnt_nxt;
            hl_mask   <= hl_mask_nxt;
            ledpin    <= pin_nxt;
            hl_active <= (hl_cnt_nxt != '0);
        end
    end
endmodule

// File: tb/tb_led_pwm_shaper.sv
// Bench for led_pwm_shaper: reference model checked every cycle, a duty table,
// and directed highlight / reset corner sequences.
module tb_led_pwm_shaper;
    localparam int DIV = 2;
    localparam int HL  = 3;

    logic        ledclk;
    logic        ledrst_n;
    logic [15:0] ledin;
    logic        brt_we;
    logic [3:0]  brt_wdata;
    logic [15:0] ledpin;
    logic        hl_active;

    led_pwm_shaper #(
        .PWM_DIV   (DIV),
        .HL_PERIODS(HL)
    ) dut (
        .ledclk   (ledclk),
        .ledrst_n (ledrst_n),
        .ledin    (ledin),
        .brt_we   (brt_we),
        .brt_wdata(brt_wdata),
        .ledpin   (ledpin),
        .hl_active(hl_active)
    );

    initial ledclk = 1'b0;
    always #5 ledclk = ~ledclk;

    // Reference model: phase derived from clocks elapsed since reset.
    int          m_t;
    logic [15:0] m_ledq, m_mask, m_pin;
    int          m_bright, m_cnt;
    logic        m_act;

    always @(posedge ledclk) begin : model
        logic [15:0] c;
        int ph, d;
        bit pe;
        if (!ledrst_n) begin
            m_t = 0; m_ledq = '0; m_mask = '0; m_pin = '0;
            m_bright = 8; m_cnt = 0; m_act = 1'b0;
        end else begin
            ph = (m_t / DIV) % 16;
            pe = ((m_t % DIV) == DIV - 1) && (ph == 15);
            for (int i = 0; i < 16; i++) begin
                d = m_mask[i] ? 15 : m_bright;
                m_pin[i] = m_ledq[i] && ((d == 15) || (ph <= d));
            end
            c = ledin ^ m_ledq;
            if (c != 16'h0) begin
                m_mask = m_mask | c;
                m_cnt  = HL;
            end else if (pe && m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_mask = '0;
            end
            m_act  = (m_cnt != 0);
            m_ledq = ledin;
            if (brt_we) m_bright = int'(brt_wdata);
            m_t = (m_t + 1) % (16 * DIV);
        end
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge ledclk);
        if (chk_en) begin
            cmp("ledpin", 32'(ledpin), 32'(m_pin));
            cmp("hl_active", 32'(hl_active), 32'(m_act));
        end
    endtask

    task automatic write_bright(input logic [3:0] b);
        brt_wdata = b;
        brt_we    = 1'b1;
        step();
        brt_we    = 1'b0;
    endtask

    task automatic wait_expire(input string name);
        for (int k = 0; k < 300 && hl_active; k++) step();
        cmp(name, 32'(hl_active), 32'd0);
        step();
    endtask

    typedef struct {
        logic [3:0]  bright;
        logic [15:0] word;
        int          exp_on;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int cnt, rise, fall, p0;
        logic [15:0] stray;
        bit found;

        tbl[0] = '{4'd3,  16'h0001, 8};
        tbl[1] = '{4'd15, 16'h0005, 32};
        tbl[2] = '{4'd14, 16'h0001, 30};
        tbl[3] = '{4'd0,  16'h8001, 2};
        tbl[4] = '{4'd7,  16'h0003, 16};

        ledrst_n = 1'b0; ledin = 16'hFFFF; brt_we = 1'b0; brt_wdata = 4'd0;

        // Reset held with all inputs high
        step();
        chk_en = 1'b1;
        step(); step();
        cmp("rst_ledpin", 32'(ledpin), 32'h0);
        cmp("rst_hl_active", 32'(hl_active), 32'd0);
        ledrst_n = 1'b1;
        step();
        cmp("rel_hl_active", 32'(hl_active), 32'd1);
        wait_expire("rst_hl_expire");

        // Duty table: steady-state on-count of bit 0 over one 32-clock period
        for (int v = 0; v < 5; v++) begin
            write_bright(tbl[v].bright);
            ledin = tbl[v].word;
            step(); step();
            wait_expire("tbl_hl_expire");
            cnt = 0; stray = '0;
            for (int k = 0; k < 32; k++) begin
                step();
                cnt += int'(ledpin[0]);
                stray |= ledpin & ~tbl[v].word;
            end
            cmp($sformatf("tbl%0d_duty", v), 32'(cnt), 32'(tbl[v].exp_on));
            cmp($sformatf("tbl%0d_stray", v), 32'(stray), 32'h0);
        end

        // Highlight on a newly set bit with bright=0
        write_bright(4'd0);
        ledin = 16'h0001;
        step(); step();
        wait_expire("hl_pre_expire");
        ledin = 16'h0003;
        rise = -1; fall = -1; p0 = 0;
        for (int k = 0; k < 140; k++) begin
            step();
            if (k < 96) p0 += int'(ledpin[0]);
            if (rise < 0 && ledpin[1]) rise = k;
            else if (rise >= 0 && fall < 0 && !ledpin[1]) fall = k;
        end
        cmp("hl_run_len_ok", 32'((rise >= 0) && (fall - rise >= 64) && (fall - rise <= 98)), 32'd1);
        cmp("hl_bit0_duty", 32'(p0), 32'd6);

        // Change lands on the period_end that would end the highlight
        ledin = 16'h0007;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (dut.hl_cnt == 8'd1 && dut.u_timebase.period_end) found = 1'b1;
        end
        cmp("sim_found", 32'(found), 32'd1);
        ledin = 16'h000F;
        step();
        cmp("sim_hl_cnt", 32'(dut.hl_cnt), 32'd3);
        cmp("sim_hl_mask", 32'(dut.hl_mask), 32'h000C);
        cmp("sim_hl_active", 32'(hl_active), 32'd1);

        // One-cycle reset while the highlight counter is at 2
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (dut.hl_cnt == 8'd2) found = 1'b1;
        end
        cmp("mid_found", 32'(found), 32'd1);
        ledrst_n = 1'b0;
        step();
        cmp("mid_hl_cnt", 32'(dut.hl_cnt), 32'd0);
        cmp("mid_bright", 32'(dut.bright), 32'd8);
        cmp("mid_ledpin", 32'(ledpin), 32'h0);
        ledrst_n = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            ledrst_n = ($urandom_range(0, 499) != 0);
            brt_we   = ($urandom_range(0, 24) == 0);
            brt_wdata = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) ledin = ledin ^ 16'($urandom);
            step();
        end
        ledrst_n = 1'b1; brt_we = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
